bcd_7seg_scan_driver: RTL and testbench



---
 rtl/bcd_disp_pkg.sv | 41 ++++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/bcd_7seg_scan_driver.sv | 130 +++++++++++++
 tb/tb_bcd_7seg_scan_driver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD 7-segment display path: sizes, segment codes
// and the digit bundle passed from the load port into the display buffers.
package bcd_disp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    // Active-high segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] digit;
        logic [NUM_DIGITS-1:0]      dp;
    } digit_bundle_t;

    // Digit i is a leading zero when it and every higher digit are zero; the
    // units digit always shows so a zero value still reads as "0".
    function automatic logic [NUM_DIGITS-1:0] leading_blank_mask(input digit_bundle_t b);
        logic [NUM_DIGITS-1:0] mask;
        logic                  higher_zero;
        mask        = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero && (b.digit[i] == 4'd0);
            mask[i]     = higher_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment decoder; non-BCD codes
// (A-F) render as a dash so corrupted input is visible on the display.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0]       bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with double-buffered digits,
// programmable scan prescaler, leading-zero blanking and per-digit points.
module bcd_7seg_scan_driver
    import bcd_disp_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [3:0]            thousands_i,
    input  logic [3:0]            hundreds_i,
    input  logic [3:0]            tens_i,
    input  logic [3:0]            units_i,
    input  logic [NUM_DIGITS-1:0] dp_en_i,
    output logic [SEG_W-1:0]      seg_o,
    output logic                  dp_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic                  frame_done_o,
    output logic                  pending_o
);

    localparam int                    CNT_W      = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]      PRESC_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [1:0]            IDX_LAST   = 2'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF    = ACTIVE_LOW_SEG ? {SEG_W{1'b1}} : SEG_BLANK;
    localparam logic                  DP_OFF     = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : '0;

    logic [CNT_W-1:0]      presc_q, presc_d;
    logic [1:0]            digit_idx_q, digit_idx_d;
    logic                  run_q;
    digit_bundle_t         pend_buf_q, pend_buf_d;
    digit_bundle_t         disp_buf_q, disp_buf_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick;
    logic                  boundary;
    digit_bundle_t         load_bundle;
    logic [3:0]            cur_nibble;
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_W-1:0]      seg_act;
    logic [NUM_DIGITS-1:0] an_act;
    logic [NUM_DIGITS-1:0] blank_mask;

    assign tick        = (presc_q == PRESC_LAST);
    assign boundary    = tick && (digit_idx_q == IDX_LAST);
    assign load_bundle = {thousands_i, hundreds_i, tens_i, units_i, dp_en_i};
    assign cur_nibble  = disp_buf_q.digit[digit_idx_q];
    assign blank_mask  = BLANK_LEADING ? leading_blank_mask(disp_buf_q) : '0;

    bcd_to_7seg u_dec (
        .bcd_i (cur_nibble),
        .seg_o (dec_seg)
    );

    // A load coincident with the boundary lands after the transfer, so the old
    // pending value is shown and the new one waits a full frame.
    always_comb begin
        presc_d      = tick ? '0 : presc_q + CNT_W'(1);
        digit_idx_d  = tick ? digit_idx_q + 2'd1 : digit_idx_q;
        frame_done_d = boundary;
        pend_buf_d   = pend_buf_q;
        disp_buf_d   = disp_buf_q;
        pending_d    = pending_q;
        if (boundary && pending_q) begin
            disp_buf_d = pend_buf_q;
            pending_d  = 1'b0;
        end
        if (load_i) begin
            pend_buf_d = load_bundle;
            pending_d  = 1'b1;
        end
    end

    // Output stage is held off for the first cycle after reset so digit 0
    // appears on the second edge; blanked digits keep their anode enabled.
    always_comb begin
        seg_act = blank_mask[digit_idx_q] ? SEG_BLANK : dec_seg;
        an_act  = NUM_DIGITS'(1) << digit_idx_q;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        an_d    = AN_OFF;
        if (run_q) begin
            seg_d = ACTIVE_LOW_SEG ? ~seg_act : seg_act;
            dp_d  = ACTIVE_LOW_SEG ? ~disp_buf_q.dp[digit_idx_q] : disp_buf_q.dp[digit_idx_q];
            an_d  = ACTIVE_LOW_AN ? ~an_act : an_act;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            digit_idx_q  <= 2'd0;
            run_q        <= 1'b0;
            pend_buf_q   <= '0;
            disp_buf_q   <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            presc_q      <= presc_d;
            digit_idx_q  <= digit_idx_d;
            run_q        <= 1'b1;
            pend_buf_q   <= pend_buf_d;
            disp_buf_q   <= disp_buf_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign an_o         = an_q;
    assign frame_done_o = frame_done_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Directed bench: one active-high blanking driver and one active-low,
// non-blanking driver share stimulus; both are checked frame by frame.
module tb_bcd_7seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [3:0] thousands, hundreds, tens, units, dpEn;

    logic [6:0] seg, segNb;
    logic       dp, dpNb;
    logic [3:0] an, anNb;
    logic       frameDone, frameDoneNb;
    logic       pending, pendingNb;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    bcd_7seg_scan_driver #(
        .CLK_DIV(4), .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_i(load),
        .thousands_i(thousands), .hundreds_i(hundreds), .tens_i(tens), .units_i(units),
        .dp_en_i(dpEn), .seg_o(seg), .dp_o(dp), .an_o(an),
        .frame_done_o(frameDone), .pending_o(pending)
    );

    bcd_7seg_scan_driver #(
        .CLK_DIV(4), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1), .BLANK_LEADING(1'b0)
    ) dutNb (
        .clk(clk), .rst_n(rst_n), .load_i(load),
        .thousands_i(thousands), .hundreds_i(hundreds), .tens_i(tens), .units_i(units),
        .dp_en_i(dpEn), .seg_o(segNb), .dp_o(dpNb), .an_o(anNb),
        .frame_done_o(frameDoneNb), .pending_o(pendingNb)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives digits {thousands,hundreds,tens,units} and dp, with optional load
    task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] dps, input logic ld);
        {thousands, hundreds, tens, units} = digits;
        dpEn = dps;
        load = ld;
    endtask

    task automatic checkOff(input string tag);
        checkOutput({tag, "_an"},     an,          32'h0);
        checkOutput({tag, "_seg"},    seg,         32'h0);
        checkOutput({tag, "_dp"},     dp,          32'h0);
        checkOutput({tag, "_pend"},   pending,     32'h0);
        checkOutput({tag, "_fd"},     frameDone,   32'h0);
        checkOutput({tag, "_anNb"},   anNb,        32'hF);
        checkOutput({tag, "_segNb"},  segNb,       32'h7F);
        checkOutput({tag, "_dpNb"},   dpNb,        32'h1);
        checkOutput({tag, "_pendNb"}, pendingNb,   32'h0);
    endtask

    task automatic waitFrameDone(input string tag);
        int n = 0;
        @(negedge clk);
        while (!frameDone && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_frameWait"}, frameDone, 32'h1);
    endtask

    // Called at the sample just after a boundary edge; checks all 16 cycles of
    // the next frame. ldVal = {T,H,Te,U,dp}; a load cycle of -1 means none.
    task automatic checkFrame(input string tag,
                              input logic [3:0][6:0] expSeg, input logic [3:0][6:0] expSegNb,
                              input logic [3:0] expDp, input bit pendStart,
                              input int ld1Cyc, input logic [19:0] ld1Val,
                              input int ld2Cyc, input logic [19:0] ld2Val);
        bit         pendExp = pendStart;
        bit         ldNow;
        int         d;
        logic [3:0] oneHot, anNbExp;
        logic [6:0] segNbExp;
        logic       dpNbExp;
        for (int c = 0; c < 16; c++) begin
            ldNow = 1'b0;
            if (c == ld1Cyc) begin
                applyStimulus(ld1Val[19:4], ld1Val[3:0], 1'b1);
                ldNow = 1'b1;
            end else if (c == ld2Cyc) begin
                applyStimulus(ld2Val[19:4], ld2Val[3:0], 1'b1);
                ldNow = 1'b1;
            end
            pendExp = (c == 15) ? ldNow : (pendExp | ldNow);
            @(negedge clk);
            load     = 1'b0;
            d        = c / 4;
            oneHot   = 4'b0001 << d;
            anNbExp  = ~oneHot;
            segNbExp = ~expSegNb[d];
            dpNbExp  = ~expDp[d];
            checkOutput({tag, "_an"},    an,        {28'h0, oneHot});
            checkOutput({tag, "_seg"},   seg,       {25'h0, expSeg[d]});
            checkOutput({tag, "_dp"},    dp,        {31'h0, expDp[d]});
            checkOutput({tag, "_fd"},    frameDone, (c == 15) ? 32'h1 : 32'h0);
            checkOutput({tag, "_pend"},  pending,   {31'h0, pendExp});
            checkOutput({tag, "_anNb"},  anNb,      {28'h0, anNbExp});
            checkOutput({tag, "_segNb"}, segNb,     {25'h0, segNbExp});
            checkOutput({tag, "_dpNb"},  dpNb,      {31'h0, dpNbExp});
        end
    endtask

    localparam logic [3:0][6:0] BLANK0   = {7'h00, 7'h00, 7'h00, 7'h3F};
    localparam logic [3:0][6:0] ZEROS    = {7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [3:0][6:0] V1234    = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [3:0][6:0] V0007    = {7'h00, 7'h00, 7'h00, 7'h07};
    localparam logic [3:0][6:0] V0007NB  = {7'h3F, 7'h3F, 7'h3F, 7'h07};
    localparam logic [3:0][6:0] V0A05    = {7'h00, 7'h40, 7'h3F, 7'h6D};
    localparam logic [3:0][6:0] V0A05NB  = {7'h3F, 7'h40, 7'h3F, 7'h6D};
    localparam logic [3:0][6:0] V2222    = {7'h5B, 7'h5B, 7'h5B, 7'h5B};
    localparam logic [3:0][6:0] V3333    = {7'h4F, 7'h4F, 7'h4F, 7'h4F};

    initial begin
        rst_n = 1'b0;
        applyStimulus(16'h0000, 4'b0000, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checkOff("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOff("firstEdge");
        @(negedge clk);
        checkOutput("secondEdge_an",  an,  32'h1);
        checkOutput("secondEdge_seg", seg, 32'h3F);
        checkOutput("secondEdge_anNb", anNb, 32'hE);
        waitFrameDone("start");

        checkFrame("idle",  BLANK0, ZEROS, 4'b0000, 1'b0, -1, 20'h0, -1, 20'h0);
        checkFrame("ld1234", BLANK0, ZEROS, 4'b0000, 1'b0, 5, {16'h1234, 4'b0000}, -1, 20'h0);
        checkFrame("show1234", V1234, V1234, 4'b0000, 1'b0, 3, {16'h0007, 4'b0100}, -1, 20'h0);
        checkFrame("show0007", V0007, V0007NB, 4'b0100, 1'b0, 10, {16'h0A05, 4'b0000}, -1, 20'h0);
        checkFrame("show0A05", V0A05, V0A05NB, 4'b0000, 1'b0,
                   2, {16'h1111, 4'b0000}, 8, {16'h2222, 4'b0000});
        checkFrame("show2222", V2222, V2222, 4'b0000, 1'b0, 15, {16'h3333, 4'b0000}, -1, 20'h0);
        checkFrame("hold2222", V2222, V2222, 4'b0000, 1'b1, -1, 20'h0, -1, 20'h0);
        checkFrame("show3333", V3333, V3333, 4'b0000, 1'b0, -1, 20'h0, -1, 20'h0);

        applyStimulus(16'h5555, 4'b1111, 1'b1);
        @(negedge clk);
        load = 1'b0;
        checkOutput("midPend", pending, 32'h1);
        repeat (8) @(negedge clk);
        checkOutput("midSlot_an",  an,  32'h4);
        checkOutput("midSlot_seg", seg, 32'h4F);
        #2 rst_n = 1'b0;
        #1 checkOff("asyncReset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOff("restartFirstEdge");
        @(negedge clk);
        checkOutput("restart_an",  an,  32'h1);
        checkOutput("restart_seg", seg, 32'h3F);
        waitFrameDone("restart");
        checkFrame("restartFrame", BLANK0, ZEROS, 4'b0000, 1'b0, -1, 20'h0, -1, 20'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
